// File: rtl/dcache_mem_interface.sv
// Memory-side interface for the L1 data cache: fill requests, a writeback FIFO with
// fill forwarding, and a single request/response memory bus shared by both.
module dcache_mem_interface #(
  parameter int unsigned CACHE_BLOCK_SIZE = 128,
  parameter int unsigned WB_DEPTH         = 4,
  parameter int unsigned OFF_BITS         = $clog2(CACHE_BLOCK_SIZE / 8)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        mem_req_vld_i,
  input  logic [31:0]                 mem_req_addr_i,
  output logic                        mem_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_o,
  input  logic                        mem_wb_vld_i,
  input  logic [31:0]                 mem_wb_addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] mem_wb_data_i,
  output logic                        wb_full_o,
  output logic                        wb_overflow_o,
  output logic                        bus_req_vld_o,
  input  logic                        bus_req_rdy_i,
  output logic                        bus_req_we_o,
  output logic [31:0]                 bus_req_addr_o,
  output logic [CACHE_BLOCK_SIZE-1:0] bus_req_wdata_o,
  input  logic                        bus_rsp_vld_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] bus_rsp_data_i
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TAG_W = 32 - OFF_BITS;

  typedef enum logic [2:0] {S_IDLE, S_FWD, S_RD_REQ, S_RD_WAIT, S_WB_REQ} state_e;

  state_e                      state_q, state_d;
  logic                        rd_pend_q, rd_pend_d;
  logic [TAG_W-1:0]            rd_tag_q, rd_tag_d;
  logic [TAG_W-1:0]            wb_tag_q [WB_DEPTH];
  logic [TAG_W-1:0]            wb_tag_d [WB_DEPTH];
  logic [CACHE_BLOCK_SIZE-1:0] wb_data_q [WB_DEPTH];
  logic [CACHE_BLOCK_SIZE-1:0] wb_data_d [WB_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        overflow_q, overflow_d;
  logic [CACHE_BLOCK_SIZE-1:0] fwd_data_q, fwd_data_d;
  logic                        resp_vld_q, resp_vld_d;
  logic [CACHE_BLOCK_SIZE-1:0] resp_data_q, resp_data_d;
  logic                        bus_vld_q, bus_vld_d, bus_we_q, bus_we_d;
  logic [TAG_W-1:0]            bus_tag_q, bus_tag_d;
  logic [CACHE_BLOCK_SIZE-1:0] bus_wdata_q, bus_wdata_d;

  logic                        full_c, push_c, pop_c, rd_clr_c, fwd_hit_c;
  logic [CACHE_BLOCK_SIZE-1:0] fwd_data_c;
  logic [PTR_W-1:0]            fwd_idx_c;
  logic                        unused_addr_bits;

  // Byte offsets never reach the bus or the block compare.
  assign unused_addr_bits = ^{mem_req_addr_i[OFF_BITS-1:0], mem_wb_addr_i[OFF_BITS-1:0]};

  assign full_c = (count_q == CNT_W'(WB_DEPTH));

  // Scan head-to-tail so the last hit is the youngest buffered copy of the block.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx_c  = '0;
    for (int unsigned k = 0; k < WB_DEPTH; k++) begin
      fwd_idx_c = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (wb_tag_q[fwd_idx_c] == rd_tag_q)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = wb_data_q[fwd_idx_c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_tag_d    = rd_tag_q;
    wb_tag_d    = wb_tag_q;
    wb_data_d   = wb_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    fwd_data_d  = fwd_data_q;
    resp_vld_d  = 1'b0;
    resp_data_d = resp_data_q;
    bus_vld_d   = bus_vld_q;
    bus_we_d    = bus_we_q;
    bus_tag_d   = bus_tag_q;
    bus_wdata_d = bus_wdata_q;
    pop_c       = 1'b0;
    rd_clr_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A full FIFO drains first; otherwise a pending fill beats writebacks.
        if (full_c || (!rd_pend_q && (count_q != '0))) begin
          state_d     = S_WB_REQ;
          bus_vld_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_tag_d   = wb_tag_q[rd_ptr_q];
          bus_wdata_d = wb_data_q[rd_ptr_q];
        end else if (rd_pend_q && fwd_hit_c) begin
          state_d    = S_FWD;
          fwd_data_d = fwd_data_c;
        end else if (rd_pend_q) begin
          state_d     = S_RD_REQ;
          bus_vld_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_tag_d   = rd_tag_q;
          bus_wdata_d = '0;
        end
      end
      S_FWD: begin
        resp_vld_d  = 1'b1;
        resp_data_d = fwd_data_q;
        rd_clr_c    = 1'b1;
        state_d     = S_IDLE;
      end
      S_RD_REQ: begin
        if (bus_req_rdy_i) begin
          bus_vld_d = 1'b0;
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus_rsp_vld_i) begin
          resp_vld_d  = 1'b1;
          resp_data_d = bus_rsp_data_i;
          rd_clr_c    = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_WB_REQ: begin
        if (bus_req_rdy_i) begin
          bus_vld_d = 1'b0;
          pop_c     = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_clr_c) rd_pend_d = 1'b0;
    if (mem_req_vld_i && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rd_tag_d  = mem_req_addr_i[31:OFF_BITS];
    end

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push_c = mem_wb_vld_i && (!full_c || pop_c);
    if (mem_wb_vld_i && full_c && !pop_c) overflow_d = 1'b1;
    if (push_c) begin
      wb_tag_d[wr_ptr_q]  = mem_wb_addr_i[31:OFF_BITS];
      wb_data_d[wr_ptr_q] = mem_wb_data_i;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= '0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        wb_tag_q[i]  <= '0;
        wb_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      fwd_data_q  <= '0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
      bus_vld_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_tag_q   <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_tag_q    <= rd_tag_d;
      wb_tag_q    <= wb_tag_d;
      wb_data_q   <= wb_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      fwd_data_q  <= fwd_data_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
      bus_vld_q   <= bus_vld_d;
      bus_we_q    <= bus_we_d;
      bus_tag_q   <= bus_tag_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign mem_resp_vld_o  = resp_vld_q;
  assign mem_resp_data_o = resp_data_q;
  assign wb_full_o       = full_c;
  assign wb_overflow_o   = overflow_q;
  assign bus_req_vld_o   = bus_vld_q;
  assign bus_req_we_o    = bus_we_q;
  assign bus_req_addr_o  = {bus_tag_q, {OFF_BITS{1'b0}}};
  assign bus_req_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_dcache_mem_interface.sv
// Scoreboard bench for dcache_mem_interface: stimulus queues expected bus transfers
// and fill responses, a negedge monitor pops and compares them as the DUT emits them.
module tb_dcache_mem_interface;

  localparam int unsigned BW = 128;

  typedef struct packed {
    logic          we;
    logic [31:0]   addr;
    logic [BW-1:0] wdata;
  } bus_t;

  localparam logic [BW-1:0] D_RD  = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
  localparam logic [BW-1:0] D_X   = 128'h3000_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [BW-1:0] D_A   = 128'hAAAA_AAAA_0000_0000_0000_0000_AAAA_AAAA;
  localparam logic [BW-1:0] D_B   = 128'hBBBB_BBBB_1111_1111_2222_2222_BBBB_BBBB;
  localparam logic [BW-1:0] D_R2  = 128'h0200_0200_0200_0200_0200_0200_0200_0200;
  localparam logic [BW-1:0] D_R6  = 128'h6666_0600_0600_0600_0600_0600_0600_6666;
  localparam logic [BW-1:0] D_R7  = 128'h7777_0700_0700_0700_0700_0700_0700_7777;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          mem_req_vld_i;
  logic [31:0]   mem_req_addr_i;
  logic          mem_resp_vld_o;
  logic [BW-1:0] mem_resp_data_o;
  logic          mem_wb_vld_i;
  logic [31:0]   mem_wb_addr_i;
  logic [BW-1:0] mem_wb_data_i;
  logic          wb_full_o;
  logic          wb_overflow_o;
  logic          bus_req_vld_o;
  logic          bus_req_rdy_i;
  logic          bus_req_we_o;
  logic [31:0]   bus_req_addr_o;
  logic [BW-1:0] bus_req_wdata_o;
  logic          bus_rsp_vld_i;
  logic [BW-1:0] bus_rsp_data_i;

  int checks = 0;
  int errors = 0;
  bus_t          bus_q[$];
  logic [BW-1:0] resp_q[$];

  dcache_mem_interface dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .mem_req_vld_i   (mem_req_vld_i),
    .mem_req_addr_i  (mem_req_addr_i),
    .mem_resp_vld_o  (mem_resp_vld_o),
    .mem_resp_data_o (mem_resp_data_o),
    .mem_wb_vld_i    (mem_wb_vld_i),
    .mem_wb_addr_i   (mem_wb_addr_i),
    .mem_wb_data_i   (mem_wb_data_i),
    .wb_full_o       (wb_full_o),
    .wb_overflow_o   (wb_overflow_o),
    .bus_req_vld_o   (bus_req_vld_o),
    .bus_req_rdy_i   (bus_req_rdy_i),
    .bus_req_we_o    (bus_req_we_o),
    .bus_req_addr_o  (bus_req_addr_o),
    .bus_req_wdata_o (bus_req_wdata_o),
    .bus_rsp_vld_i   (bus_rsp_vld_i),
    .bus_rsp_data_i  (bus_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [BW-1:0] data);
    bus_t t;
    t.we = 1'b1; t.addr = addr; t.wdata = data;
    bus_q.push_back(t);
  endtask

  task automatic exp_rd(input logic [31:0] addr);
    bus_t t;
    t.we = 1'b0; t.addr = addr; t.wdata = '0;
    bus_q.push_back(t);
  endtask

  task automatic push_wb(input logic [31:0] addr, input logic [BW-1:0] data);
    mem_wb_vld_i  = 1'b1;
    mem_wb_addr_i = addr;
    mem_wb_data_i = data;
    tick();
    mem_wb_vld_i  = 1'b0;
  endtask

  task automatic fill(input logic [31:0] addr);
    mem_req_vld_i  = 1'b1;
    mem_req_addr_i = addr;
    tick();
    mem_req_vld_i  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((bus_q.size() != 0 || resp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    check(name, BW'(bus_q.size() + resp_q.size()), '0);
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp_vld"}, BW'(mem_resp_vld_o), '0);
    check({tag, "_resp_data"}, mem_resp_data_o, '0);
    check({tag, "_full"}, BW'(wb_full_o), '0);
    check({tag, "_ovf"}, BW'(wb_overflow_o), '0);
    check({tag, "_bus_vld"}, BW'(bus_req_vld_o), '0);
    check({tag, "_bus_we"}, BW'(bus_req_we_o), '0);
    check({tag, "_bus_addr"}, BW'(bus_req_addr_o), '0);
    check({tag, "_bus_wdata"}, bus_req_wdata_o, '0);
  endtask

  // Monitor: a transfer happens on the next edge whenever valid and ready are both high.
  initial begin
    bus_t e;
    logic [BW-1:0] r;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1) begin
        if (bus_req_vld_o && bus_req_rdy_i) begin
          checks++;
          if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_xfer: unexpected we=%0b addr=%h", bus_req_we_o, bus_req_addr_o);
          end else begin
            e = bus_q.pop_front();
            if (bus_req_we_o !== e.we || bus_req_addr_o !== e.addr ||
                (e.we && bus_req_wdata_o !== e.wdata)) begin
              errors++;
              $display("FAIL bus_xfer: got we=%0b addr=%h wdata=%h expected we=%0b addr=%h wdata=%h",
                       bus_req_we_o, bus_req_addr_o, bus_req_wdata_o, e.we, e.addr, e.wdata);
            end
          end
        end
        if (mem_resp_vld_o) begin
          checks++;
          if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL fill_resp: unexpected data %h", mem_resp_data_o);
          end else begin
            r = resp_q.pop_front();
            if (mem_resp_data_o !== r) begin
              errors++;
              $display("FAIL fill_resp: got %h expected %h", mem_resp_data_o, r);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem_req_vld_i  = 1'b0;
    mem_req_addr_i = '0;
    mem_wb_vld_i   = 1'b0;
    mem_wb_addr_i  = '0;
    mem_wb_data_i  = '0;
    bus_req_rdy_i  = 1'b0;
    bus_rsp_vld_i  = 1'b0;
    bus_rsp_data_i = '0;
    rst_ni         = 1'b1;
    #2 rst_ni = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // Read miss with an idle FIFO: request at N+2, response one cycle after bus data.
    bus_req_rdy_i = 1'b1;
    exp_rd(32'h0000_1230);
    fill(32'h0000_1234);
    check("miss_vld_n1", BW'(bus_req_vld_o), '0);
    tick();
    check("miss_vld_n2", BW'(bus_req_vld_o), BW'(1));
    check("miss_addr", BW'(bus_req_addr_o), BW'(32'h0000_1230));
    check("miss_we", BW'(bus_req_we_o), '0);
    tick();
    resp_q.push_back(D_RD);
    bus_rsp_vld_i  = 1'b1;
    bus_rsp_data_i = D_RD;
    check("miss_resp_m", BW'(mem_resp_vld_o), '0);
    tick();
    bus_rsp_vld_i = 1'b0;
    check("miss_resp_m1", BW'(mem_resp_vld_o), BW'(1));
    check("miss_resp_data", mem_resp_data_o, D_RD);
    tick();
    check("miss_resp_pulse", BW'(mem_resp_vld_o), '0);
    wait_drain("miss_drain");

    // Forwarding: youngest of two buffered copies of block 0x100 answers the fill.
    bus_req_rdy_i = 1'b0;
    exp_wr(32'h0000_0300, D_X);
    exp_wr(32'h0000_0100, D_A);
    exp_wr(32'h0000_0100, D_B);
    resp_q.push_back(D_B);
    push_wb(32'h0000_0300, D_X);
    push_wb(32'h0000_0100, D_A);
    push_wb(32'h0000_0100, D_B);
    fill(32'h0000_0108);
    check("fwd_stall_vld", BW'(bus_req_vld_o), BW'(1));
    check("fwd_stall_addr", BW'(bus_req_addr_o), BW'(32'h0000_0300));
    bus_req_rdy_i = 1'b1;
    tick();
    tick();
    check("fwd_no_bus", BW'(bus_req_vld_o), '0);
    check("fwd_resp_early", BW'(mem_resp_vld_o), '0);
    tick();
    check("fwd_resp_vld", BW'(mem_resp_vld_o), BW'(1));
    check("fwd_resp_data", mem_resp_data_o, D_B);
    wait_drain("fwd_drain");

    // Full FIFO drains its head before a pending read; the rest follow the response.
    bus_req_rdy_i = 1'b0;
    exp_wr(32'h0000_0400, D_A ^ BW'(4));
    exp_rd(32'h0000_0200);
    exp_wr(32'h0000_0410, D_A ^ BW'(5));
    exp_wr(32'h0000_0420, D_A ^ BW'(6));
    exp_wr(32'h0000_0430, D_A ^ BW'(7));
    resp_q.push_back(D_R2);
    for (int i = 0; i < 4; i++) push_wb(32'h0000_0400 + 32'(i * 16), D_A ^ BW'(4 + i));
    check("prio_full", BW'(wb_full_o), BW'(1));
    fill(32'h0000_0200);
    bus_req_rdy_i = 1'b1;
    tick();
    tick();
    check("prio_rd_vld", BW'(bus_req_vld_o), BW'(1));
    check("prio_rd_we", BW'(bus_req_we_o), '0);
    check("prio_rd_addr", BW'(bus_req_addr_o), BW'(32'h0000_0200));
    tick();
    bus_rsp_vld_i  = 1'b1;
    bus_rsp_data_i = D_R2;
    tick();
    bus_rsp_vld_i = 1'b0;
    check("prio_resp_vld", BW'(mem_resp_vld_o), BW'(1));
    wait_drain("prio_drain");

    // Overflow: a fifth push while stalled is dropped and the flag sticks.
    bus_req_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_wr(32'h0000_0500 + 32'(i * 16), D_B ^ BW'(i));
      push_wb(32'h0000_0500 + 32'(i * 16), D_B ^ BW'(i));
    end
    check("ovf_full", BW'(wb_full_o), BW'(1));
    check("ovf_pre", BW'(wb_overflow_o), '0);
    push_wb(32'h0000_0540, D_X);
    check("ovf_set", BW'(wb_overflow_o), BW'(1));
    tick();
    tick();
    tick();
    check("ovf_sticky", BW'(wb_overflow_o), BW'(1));
    bus_req_rdy_i = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_full_clr", BW'(wb_full_o), '0);
    check("ovf_sticky_end", BW'(wb_overflow_o), BW'(1));

    // Backpressure: request held stable for five cycles, one transfer on release.
    bus_req_rdy_i = 1'b0;
    exp_rd(32'h0000_0600);
    fill(32'h0000_0604);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", BW'(bus_req_vld_o), BW'(1));
      check("bp_addr", BW'(bus_req_addr_o), BW'(32'h0000_0600));
      check("bp_we", BW'(bus_req_we_o), '0);
      if (i == 4) bus_req_rdy_i = 1'b1;
      tick();
    end
    check("bp_single", BW'(bus_req_vld_o), '0);
    resp_q.push_back(D_R6);
    bus_rsp_vld_i  = 1'b1;
    bus_rsp_data_i = D_R6;
    tick();
    bus_rsp_vld_i = 1'b0;
    check("bp_resp_vld", BW'(mem_resp_vld_o), BW'(1));
    wait_drain("bp_drain");

    // Asynchronous reset while waiting for read data, with a writeback buffered.
    exp_rd(32'h0000_0700);
    fill(32'h0000_0700);
    tick();
    tick();
    push_wb(32'h0000_0800, D_X);
    #2 rst_ni = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    bus_rsp_vld_i  = 1'b1;
    bus_rsp_data_i = D_R7;
    tick();
    bus_rsp_vld_i = 1'b0;
    check("arst_no_resp", BW'(mem_resp_vld_o), '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_bus", BW'(bus_req_vld_o), '0);
    end
    check("final_bus_q", BW'(bus_q.size()), '0);
    check("final_resp_q", BW'(resp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
